// File: rtl/servo_pwm_if.sv
// Servo PWM decoder bus: raw PWM line in, decoded width/angle and status out.
// The slave modport is the decoder side and the master modport is the side that drives pwm_in.
interface servo_pwm_if;
    logic        pwm_in;
    logic [15:0] width_us;
    logic [7:0]  angle;
    logic        angle_valid;
    logic        pulse_err;
    logic        signal_lost;
    logic [1:0]  dbg_state;

    // pwm_in is asynchronous.
    // angle_valid and pulse_err are single-cycle strobes and are mutually exclusive.
    // signal_lost and the data outputs are levels.
    modport slave (
        input  pwm_in,
        output width_us, angle, angle_valid, pulse_err, signal_lost, dbg_state
    );
    modport master (
        output pwm_in,
        input  width_us, angle, angle_valid, pulse_err, signal_lost, dbg_state
    );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time in microseconds and converts it to an angle from 0 to 180 degrees.
// Optional macro PWM_GLITCH_FILTER_EN requires 4 stable clocks before the filtered level changes.
module servo_pwm_decoder #(
    parameter int TICKS_PER_US = 50,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    servo_pwm_if.slave  bus
);
    localparam int              PW           = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0]   PRESC_MAX    = PW'(TICKS_PER_US - 1);
    localparam logic [31:0]     TIMEOUT_FULL = 32'(TIMEOUT_US);
    localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT_US - 1);
    localparam logic [15:0]     W_MIN        = 16'd800;
    localparam logic [15:0]     W_OVER       = 16'd2201;
    localparam logic [15:0]     W_LO         = 16'd1000;
    localparam logic [15:0]     W_HI         = 16'd2000;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2} state_t;

    state_t        r_state;
    logic          r_sync1, r_sync2, r_level_q;
    logic [1:0]    r_warm;
    logic          r_armed;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_width;
    logic [31:0]   r_since;
    logic [15:0]   r_width_us;
    logic [7:0]    r_angle;
    logic          r_angle_valid, r_pulse_err, r_signal_lost;

    logic          w_level, w_rise, w_fall, w_tick, w_to;
    logic [15:0]   w_width_eff, w_wc;
    logic [19:0]   w_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    logic       r_filt;
    logic [1:0] r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_hold <= 2'd0;
        end else if (r_sync2 == r_filt) begin
            r_hold <= 2'd0;
        end else if (r_hold == 2'd3) begin
            r_filt <= r_sync2;
            r_hold <= 2'd0;
        end else begin
            r_hold <= r_hold + 2'd1;
        end
    end

    // The level flips on the 4th consecutive differing clock, not one clock after it.
    assign w_level = (r_sync2 != r_filt && r_hold == 2'd3) ? r_sync2 : r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign w_rise = w_level & ~r_level_q;
    assign w_fall = ~w_level & r_level_q;
    assign w_tick = (r_presc == PRESC_MAX);
    assign w_to   = ~w_rise & w_tick & (r_since == TIMEOUT_LAST);

    // Whole microseconds elapsed since the rising edge, including the current cycle.
    assign w_width_eff = (w_tick && r_width != 16'hFFFF) ? r_width + 16'd1 : r_width;
    assign w_wc   = (w_width_eff < W_LO) ? W_LO : ((w_width_eff > W_HI) ? W_HI : w_width_eff);
    assign w_prod = 20'(w_wc - W_LO) * 20'd737 + 20'd2048;

    // A rise is accepted only after a real low has been seen, so a reset inside a pulse cannot start a measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
            r_warm    <= 2'd0;
            r_armed   <= 1'b0;
        end else begin
            r_level_q <= w_level;
            if (r_warm != 2'd2)
                r_warm <= r_warm + 2'd1;
            if (r_warm == 2'd2 && !r_sync2 && !w_level)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_width <= 16'd0;
            r_since <= 32'd0;
        end else begin
            if (w_rise || w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;

            if (w_rise || w_to)
                r_width <= 16'd0;
            else if (r_state == S_HIGH && w_tick && r_width != 16'hFFFF)
                r_width <= r_width + 16'd1;

            if (w_rise)
                r_since <= 32'd0;
            else if (w_tick && r_since < TIMEOUT_FULL)
                r_since <= r_since + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_width_us    <= 16'd0;
            r_angle       <= 8'd0;
            r_angle_valid <= 1'b0;
            r_pulse_err   <= 1'b0;
            r_signal_lost <= 1'b1;
        end else begin
            r_angle_valid <= 1'b0;
            r_pulse_err   <= 1'b0;
            if (w_to) begin
                r_state       <= S_IDLE;
                r_signal_lost <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (w_rise && r_armed) r_state <= S_HIGH;
                    S_HIGH: begin
                        if (w_width_eff >= W_OVER) begin
                            r_pulse_err <= 1'b1;
                            r_state     <= S_LOW;
                        end else if (w_fall) begin
                            r_state <= S_LOW;
                            if (w_width_eff < W_MIN) begin
                                r_pulse_err <= 1'b1;
                            end else begin
                                r_width_us    <= w_wc;
                                r_angle       <= 8'(w_prod >> 12);
                                r_angle_valid <= 1'b1;
                                r_signal_lost <= 1'b0;
                            end
                        end
                    end
                    S_LOW:  if (w_rise) r_state <= S_HIGH;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.width_us    = r_width_us;
    assign bus.angle       = r_angle;
    assign bus.angle_valid = r_angle_valid;
    assign bus.pulse_err   = r_pulse_err;
    assign bus.signal_lost = r_signal_lost;
    assign bus.dbg_state   = r_state;
endmodule
